// File: rtl/ex_operand_stage.sv
// ---------------------------------------------------------------------------
// ex_operand_stage
//   ID/EX pipeline register plus EX-stage operand selection for the 16-bit,
//   8-register pipelined core. Latches decoded ID fields, exposes the latched
//   source register numbers to the forwarding unit, applies that unit's
//   FwdA/FwdB selects to build the ALU operands, detects load-use hazards
//   (stalling ID and inserting a bubble into EX), and handles flush and
//   downstream hold.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   p2_valid                    ID holds a real instruction
//   p2_RegRs/Rt/Rd              decoded register numbers (AW bits)
//   p2_RsData/RtData            register-file read data (DW bits)
//   p2_RegWren, p2_MemRead      writes a register / is a load
//   flush                       squash the instruction entering EX
//   ex_hold                     downstream freeze of EX
//   FwdA, FwdB                  forwarding selects (00 own, 10 p3, 01 p4, 11 p3)
//   p3_Result, p4_Result        results one / two stages ahead of EX
//   ex_valid/RegWren/MemRead    latched control
//   ex_RegRs/Rt/Rd              latched register numbers
//   OpA, OpB                    forwarded ALU operands
//   stall_id                    hold PC and IF/ID this cycle
// ---------------------------------------------------------------------------
module ex_operand_stage #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p2_valid,
  input  logic [AW-1:0] p2_RegRs,
  input  logic [AW-1:0] p2_RegRt,
  input  logic [AW-1:0] p2_RegRd,
  input  logic [DW-1:0] p2_RsData,
  input  logic [DW-1:0] p2_RtData,
  input  logic          p2_RegWren,
  input  logic          p2_MemRead,
  input  logic          flush,
  input  logic          ex_hold,
  input  logic [1:0]    FwdA,
  input  logic [1:0]    FwdB,
  input  logic [DW-1:0] p3_Result,
  input  logic [DW-1:0] p4_Result,
  output logic          ex_valid,
  output logic          ex_RegWren,
  output logic          ex_MemRead,
  output logic [AW-1:0] ex_RegRs,
  output logic [AW-1:0] ex_RegRt,
  output logic [AW-1:0] ex_RegRd,
  output logic [DW-1:0] OpA,
  output logic [DW-1:0] OpB,
  output logic          stall_id
);

  logic          r_ex_valid;
  logic          r_ex_reg_wren;
  logic          r_ex_mem_read;
  logic [AW-1:0] r_ex_reg_rs;
  logic [AW-1:0] r_ex_reg_rt;
  logic [AW-1:0] r_ex_reg_rd;
  logic [DW-1:0] r_ex_rs_data;
  logic [DW-1:0] r_ex_rt_data;

  logic          w_load_use;
  logic [DW-1:0] w_op_a;
  logic [DW-1:0] w_op_b;

  // The nearer producer (p3) wins when both forwarding bits are set.
  function automatic logic [DW-1:0] f_fwd(input logic [1:0]    sel,
                                          input logic [DW-1:0] own,
                                          input logic [DW-1:0] p3,
                                          input logic [DW-1:0] p4);
    logic [DW-1:0] res;
    case (sel)
      2'b10, 2'b11: res = p3;
      2'b01:        res = p4;
      default:      res = own;
    endcase
    return res;
  endfunction

  always_comb begin
    w_op_a = f_fwd(FwdA, r_ex_rs_data, p3_Result, p4_Result);
    w_op_b = f_fwd(FwdB, r_ex_rt_data, p3_Result, p4_Result);
  end

  // Load in EX whose destination is read by the instruction sitting in ID.
  assign w_load_use = r_ex_valid & r_ex_mem_read & r_ex_reg_wren & p2_valid &
                      ((r_ex_reg_rd == p2_RegRs) | (r_ex_reg_rd == p2_RegRt));

  // A flush squashes the ID instruction anyway, so stalling it is pointless.
  assign stall_id = (w_load_use | ex_hold) & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid    <= 1'b0;
      r_ex_reg_wren <= 1'b0;
      r_ex_mem_read <= 1'b0;
      r_ex_reg_rs   <= '0;
      r_ex_reg_rt   <= '0;
      r_ex_reg_rd   <= '0;
      r_ex_rs_data  <= '0;
      r_ex_rt_data  <= '0;
    end else if (flush || (!ex_hold && w_load_use)) begin
      // Bubble: only the control bits are cleared, so a bubble never
      // looks like a register writer to the forwarding unit.
      r_ex_valid    <= 1'b0;
      r_ex_reg_wren <= 1'b0;
      r_ex_mem_read <= 1'b0;
    end else if (ex_hold) begin
      // Capture forwarded operands so they survive their producer retiring.
      r_ex_rs_data  <= w_op_a;
      r_ex_rt_data  <= w_op_b;
    end else begin
      r_ex_valid    <= p2_valid;
      r_ex_reg_wren <= p2_RegWren & p2_valid;
      r_ex_mem_read <= p2_MemRead & p2_valid;
      r_ex_reg_rs   <= p2_RegRs;
      r_ex_reg_rt   <= p2_RegRt;
      r_ex_reg_rd   <= p2_RegRd;
      r_ex_rs_data  <= p2_RsData;
      r_ex_rt_data  <= p2_RtData;
    end
  end

  assign ex_valid   = r_ex_valid;
  assign ex_RegWren = r_ex_reg_wren;
  assign ex_MemRead = r_ex_mem_read;
  assign ex_RegRs   = r_ex_reg_rs;
  assign ex_RegRt   = r_ex_reg_rt;
  assign ex_RegRd   = r_ex_reg_rd;
  assign OpA        = w_op_a;
  assign OpB        = w_op_b;

endmodule
